// File: rtl/lcd_pkg.sv
// Shared LCD definitions: timing defaults, RS encodings and state encodings
// used by both the read path and the write/init path.
package lcd_pkg;

  // Timing defaults in 50 MHz clocks, common to both ends of the LCD bus
  localparam int unsigned LCD_T_SETUP  = 2;     // RS/RW valid to E rise (tAS)
  localparam int unsigned LCD_T_EHIGH  = 12;    // E high per nibble
  localparam int unsigned LCD_T_GAP    = 50;    // E low between nibbles / after a byte
  localparam int unsigned LCD_POLL_MAX = 1000;  // busy-flag reads before giving up
  localparam int unsigned LCD_CNT_W    = 16;    // timing counter width

  // Register select encodings
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Byte-level read sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HI_PULSE,
    ST_HI_GAP,
    ST_LO_PULSE,
    ST_LO_GAP,
    ST_CHECK
  } rd_state_t;

  // Phases of a single nibble read
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_GAP
  } nib_phase_t;

endpackage

// File: rtl/lcd_nibble_read.sv
// One nibble read: optional RS/RW setup wait, E high pulse with a sample of
// the data pins on the last high cycle, then E-low recovery gap.
module lcd_nibble_read
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = LCD_T_SETUP,
  parameter int unsigned T_EHIGH = LCD_T_EHIGH,
  parameter int unsigned T_GAP   = LCD_T_GAP,
  parameter int unsigned CNT_W   = LCD_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,          // launch a nibble read (may coincide with done_c)
  input  logic       with_setup,  // precede the pulse with the setup wait
  input  logic [3:0] sf_d_in,
  output logic       lcd_e,
  output logic [3:0] nibble,
  output logic       e_rise_c,    // E rises on the next clock
  output logic       e_fall_c,    // E falls and nibble is sampled on the next clock
  output logic       done_c       // last gap cycle
);

  nib_phase_t       phase;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);
  assign e_rise_c = (phase == PH_SETUP) && cnt_zero;
  assign e_fall_c = (phase == PH_PULSE) && cnt_zero;
  assign done_c   = (phase == PH_GAP)   && cnt_zero;

  // Phase sequencing; counter reloads on every phase entry and holds at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      nibble <= 4'h0;
    end else if (go) begin
      if (with_setup) begin
        phase <= PH_SETUP;
        cnt   <= CNT_W'(T_SETUP - 1);
        lcd_e <= 1'b0;
      end else begin
        phase <= PH_PULSE;
        cnt   <= CNT_W'(T_EHIGH - 1);
        lcd_e <= 1'b1;
      end
    end else begin
      unique case (phase)
        PH_SETUP: begin
          if (cnt_zero) begin
            phase <= PH_PULSE;
            cnt   <= CNT_W'(T_EHIGH - 1);
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PH_PULSE: begin
          if (cnt_zero) begin
            nibble <= sf_d_in;
            lcd_e  <= 1'b0;
            phase  <= PH_GAP;
            cnt    <= CNT_W'(T_GAP - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PH_GAP: begin
          if (cnt_zero) begin
            phase <= PH_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          phase <= PH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read transaction: two nibble reads (high first) assembled
// into a byte, with optional busy-flag polling until BF clears or times out.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP  = LCD_T_SETUP,
  parameter int unsigned T_EHIGH  = LCD_T_EHIGH,
  parameter int unsigned T_GAP    = LCD_T_GAP,
  parameter int unsigned POLL_MAX = LCD_POLL_MAX,
  parameter int unsigned CNT_W    = LCD_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic       poll_in,
  input  logic [3:0] sf_d_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       bus_own,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       timeout,
  output logic       ready
);

  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  rd_state_t         state;
  logic              poll_mode;
  logic [POLL_W-1:0] poll_cnt;
  logic [7:0]        shadow;

  logic       accept_c;
  logic       retry_c;
  logic       go_c;
  logic       with_setup_c;
  logic       e_rise_c;
  logic       e_fall_c;
  logic       done_c;
  logic [3:0] nibble;

  assign accept_c     = (state == ST_IDLE) && ready && start;
  assign retry_c      = poll_mode && shadow[7] && (poll_cnt < POLL_W'(POLL_MAX));
  // Second nibble launches straight into its E pulse at the end of the first gap
  assign go_c         = accept_c
                      | ((state == ST_HI_GAP) && done_c)
                      | ((state == ST_CHECK) && retry_c);
  assign with_setup_c = (state != ST_HI_GAP);

  lcd_nibble_read #(
    .T_SETUP (T_SETUP),
    .T_EHIGH (T_EHIGH),
    .T_GAP   (T_GAP),
    .CNT_W   (CNT_W)
  ) u_nibble (
    .clk        (clk),
    .rst        (rst),
    .go         (go_c),
    .with_setup (with_setup_c),
    .sf_d_in    (sf_d_in),
    .lcd_e      (lcd_e),
    .nibble     (nibble),
    .e_rise_c   (e_rise_c),
    .e_fall_c   (e_fall_c),
    .done_c     (done_c)
  );

  // Transaction FSM with registered pin controls and status strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      poll_mode <= 1'b0;
      poll_cnt  <= '0;
      shadow    <= 8'h00;
      lcd_rs    <= RS_CMD;
      lcd_rw    <= 1'b0;
      bus_own   <= 1'b0;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      ready     <= 1'b1;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            lcd_rs    <= poll_in ? RS_CMD : rs_in;
            lcd_rw    <= 1'b1;
            bus_own   <= 1'b1;
            ready     <= 1'b0;
            poll_mode <= poll_in;
            poll_cnt  <= '0;
            state     <= ST_SETUP;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (e_rise_c) state <= ST_HI_PULSE;
        end
        ST_HI_PULSE: begin
          if (e_fall_c) state <= ST_HI_GAP;
        end
        ST_HI_GAP: begin
          if (done_c) begin
            shadow[7:4] <= nibble;
            state       <= ST_LO_PULSE;
          end
        end
        ST_LO_PULSE: begin
          if (e_fall_c) state <= ST_LO_GAP;
        end
        ST_LO_GAP: begin
          if (done_c) begin
            shadow[3:0] <= nibble;
            state       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!poll_mode || !shadow[7]) begin
            data_out <= shadow;
            valid    <= 1'b1;
            lcd_rs   <= RS_CMD;
            lcd_rw   <= 1'b0;
            bus_own  <= 1'b0;
            state    <= ST_IDLE;
          end else if (retry_c) begin
            // Still busy: re-read with RS/RW and bus ownership held
            poll_cnt <= poll_cnt + POLL_W'(1);
            state    <= ST_SETUP;
          end else begin
            timeout <= 1'b1;
            lcd_rs  <= RS_CMD;
            lcd_rw  <= 1'b0;
            bus_own <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-direction counterpart to the LCD write/init path, for the Spartan-3E character LCD (HD44780-compatible) in 4-bit mode.
- Performs one 8-bit read transaction as two nibble reads, high nibble first:
  - lcd_rs=0 returns busy flag and address counter.
  - lcd_rs=1 returns DDRAM/CGRAM data.
- Optional poll mode repeats busy-flag reads until BF=0 or a retry limit is reached. The top level then issues the next command on BF clear instead of a fixed worst-case delay.
- Owns the LCD control pins only while bus_own=1; the top-level mux selects between this block and the write path.

Parameters:
- T_SETUP, 2, clocks from RS/RW valid to E rise (tAS ≥ 40 ns at 50 MHz)
- T_EHIGH, 12, clocks E held high per nibble (≥ 230 ns); sample taken on last high cycle
- T_GAP, 50, clocks E low between nibbles and after the second nibble (≥ 1 µs)
- POLL_MAX, 1000, max busy-flag reads in poll mode before timeout
- CNT_W, 16, timing counter width

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; accepted only when ready=1
- rs_in  in  1  register select for the transaction; ignored when poll_in=1
- poll_in  in  1  busy-flag poll mode
- sf_d_in  in  4  LCD data pins DB7..DB4, pad input
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW (1 = read)
- lcd_e  out  1  LCD enable
- bus_own  out  1  high while a transaction is active; top level tri-states the FPGA drivers on SF_D
- data_out  out  8  last byte read
- valid  out  1  one-cycle pulse when data_out updates
- timeout  out  1  one-cycle pulse when poll exhausts POLL_MAX
- ready  out  1  idle and able to accept start

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; counters cleared.
  - lcd_rs=0, lcd_rw=0, lcd_e=0, bus_own=0, data_out=8'h00, valid=0, timeout=0, ready=1.
  - Reset mid-transaction drops E immediately; no partial data is reported.
- All outputs are registered.
- States and transitions:
  - IDLE: ready=1. On start, latch rs=(poll_in ? 0 : rs_in) and poll mode; set lcd_rs, lcd_rw=1, bus_own=1, ready=0 → SETUP.
  - SETUP: E low for T_SETUP cycles → HI_PULSE.
  - HI_PULSE: lcd_e=1 for T_EHIGH cycles; on the last cycle capture sf_d_in into data_out[7:4] (shadow register) → HI_GAP with lcd_e=0.
  - HI_GAP: E low for T_GAP cycles → LO_PULSE.
  - LO_PULSE: as HI_PULSE, capturing into [3:0] → LO_GAP.
  - LO_GAP: E low for T_GAP cycles → CHECK.
  - CHECK:
    - Non-poll: commit the shadow byte to data_out, pulse valid, lcd_rw=0, bus_own=0 → IDLE.
    - Poll with byte[7]=0: commit, pulse valid → IDLE.
    - Poll with byte[7]=1 and reads < POLL_MAX: increment the read count → SETUP, keeping bus_own and rw asserted.
    - Poll with reads = POLL_MAX: pulse timeout, leave data_out unchanged → IDLE.
- Latency, non-poll: start accepted at cycle 0; valid asserted at cycle 1+T_SETUP+2·(T_EHIGH+T_GAP)+1 = 128 with defaults; ready returns the following cycle.
- Each poll retry costs 2+2·(12+50)+1 = 127 cycles.
- lcd_rw falls only after E has been low ≥ T_GAP (satisfies tAH).
- RS and RW are stable for the whole transaction.
- start while ready=0 is ignored; no queueing.
- start and rst in the same cycle: reset wins.
- The timing counter saturates at its terminal value and reloads at each state entry. No wrap-around: CNT_W must exceed log2(T_GAP).
- The poll counter is ceil(log2(POLL_MAX+1)) bits and clears on each accepted start.

Decomposition:
- Shared package `lcd_pkg`:
  - state encoding constants
  - the timing defaults (T_SETUP, T_EHIGH, T_GAP), shared with the write path so both ends meet the same LCD timing
  - RS encodings (RS_CMD=0, RS_DATA=1)
- Sub-module `lcd_nibble_read`: performs one setup/E-pulse/gap/sample cycle and returns a nibble plus a done strobe. Instantiated once and reused for both nibbles by the FSM.

Test Plan:
- rst mid-HI_PULSE (lcd_e=1) → lcd_e=0, bus_own=0, ready=1 in the same cycle; no valid pulse afterwards.
- start, rs_in=1, model drives 4'hA then 4'h5 during the E pulses → valid at cycle 128 with data_out=8'hA5; lcd_rs=1 and lcd_rw=1 throughout; E high exactly 12 cycles each, 50 low between.
- start, poll_in=1, model returns BF byte 8'h80 for 3 reads, then 8'h07 → exactly 4 E-pulse pairs; valid with data_out=8'h07; lcd_rs=0 throughout; no timeout.
- poll_in=1, model always returns 8'hC0, POLL_MAX=4 → timeout pulse after the 5th read; data_out keeps its previous value; ready=1 next cycle.
- start pulsed again at cycles 10 and 60 of a transaction → ignored; exactly one valid pulse results.
- Timing checker: RS/RW valid ≥ 2 cycles before every E rise; RW held ≥ 50 cycles after the last E fall; bus_own is never 0 while lcd_e=1.
